// File: rtl/mpu_pkg.sv
// -----------------------------------------------------------------------------
// mpu_pkg
// Shared definitions for the Simple MPU command sequencer:
//   - mpu_state_e : 4-bit state encoding shared by the frame parser and the
//                   response serializer
//   - ST_*        : status codes returned as the first response byte
//   - SYNC_BYTE_DEFAULT : first byte of every command frame
//   - frame_csum  : checksum over the three payload bytes of a frame
// -----------------------------------------------------------------------------
package mpu_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      GET_A    = 4'd1,
      GET_B    = 4'd2,
      GET_OP   = 4'd3,
      GET_CS   = 4'd4,
      EXEC     = 4'd5,
      SEND_ST  = 4'd6,
      WAIT_ST  = 4'd7,
      SEND_RES = 4'd8,
      WAIT_RES = 4'd9
   } mpu_state_e;

   localparam logic [7:0] ST_OK    = 8'h00;
   localparam logic [7:0] ST_CSUM  = 8'hE1;
   localparam logic [7:0] ST_RXERR = 8'hE2;
   localparam logic [7:0] ST_TMO   = 8'hE3;
   localparam logic [7:0] ST_BADOP = 8'hE4;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   function automatic logic [7:0] frame_csum(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [7:0] op);
      return a ^ b ^ op;
   endfunction

endpackage

// File: rtl/mpu_resp_tx.sv
// -----------------------------------------------------------------------------
// mpu_resp_tx
// Two-byte response serializer (status byte, then result byte) driving the
// UART Tx start/busy handshake.
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : one-cycle request; st_byte_i/res_byte_i captured with it
//   st_byte_i      : status byte to send first
//   res_byte_i     : result byte to send second
//   tx_busy_i      : UART Tx busy
//   tx_data_o      : byte presented to the UART, held until the next send
//   tx_start_o     : one-cycle transmit request (registered)
//   last_status_o  : status byte of the most recent response
//   done_o         : one-cycle pulse when the result byte has gone out
// -----------------------------------------------------------------------------
module mpu_resp_tx
   import mpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] st_byte_i,
   input  logic [7:0] res_byte_i,
   input  logic       tx_busy_i,
   output logic [7:0] tx_data_o,
   output logic       tx_start_o,
   output logic [7:0] last_status_o,
   output logic       done_o
);

   mpu_state_e state_q, state_d;
   logic       guard_q, guard_d;
   logic [7:0] st_q, st_d;
   logic [7:0] res_q, res_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_start_q, tx_start_d;
   logic [7:0] last_status_q, last_status_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         guard_q       <= 1'b0;
         st_q          <= 8'h00;
         res_q         <= 8'h00;
         tx_data_q     <= 8'h00;
         tx_start_q    <= 1'b0;
         last_status_q <= 8'h00;
      end else begin
         state_q       <= state_d;
         guard_q       <= guard_d;
         st_q          <= st_d;
         res_q         <= res_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         last_status_q <= last_status_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      guard_d       = 1'b0;
      st_d          = st_q;
      res_d         = res_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      last_status_d = last_status_q;
      done_o        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               st_d    = st_byte_i;
               res_d   = res_byte_i;
               state_d = SEND_ST;
            end
         end
         SEND_ST: begin
            if (!tx_busy_i) begin
               tx_data_d     = st_q;
               tx_start_d    = 1'b1;
               last_status_d = st_q;
               guard_d       = 1'b1;
               state_d       = WAIT_ST;
            end
         end
         WAIT_ST: begin
            // tx_busy only rises the cycle after tx_start, so the first
            // cycle here would otherwise see a stale "not busy".
            if (!guard_q && !tx_busy_i) begin
               state_d = SEND_RES;
            end
         end
         SEND_RES: begin
            if (!tx_busy_i) begin
               tx_data_d  = res_q;
               tx_start_d = 1'b1;
               guard_d    = 1'b1;
               state_d    = WAIT_RES;
            end
         end
         WAIT_RES: begin
            if (!guard_q && !tx_busy_i) begin
               done_o  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_data_o     = tx_data_q;
   assign tx_start_o    = tx_start_q;
   assign last_status_o = last_status_q;

endmodule

// File: rtl/mpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// mpu_cmd_sequencer
// Framed-command controller between the UART Rx/Tx pair and the ALU.
// Parses SYNC,A,B,OP,CS frames, runs the ALU for ALU_LAT cycles and returns a
// (status, result) response through mpu_resp_tx.
//   clk, rst          : clock, synchronous active-high reset
//   rx_data           : received byte, valid with rx_complete
//   rx_complete       : one-cycle pulse per received byte
//   rx_error          : one-cycle pulse on Rx framing error
//   alu_result        : ALU output
//   a_reg/b_reg/f_reg : ALU operands and function, loaded on good frames only
//   tx_data/tx_start  : UART Tx byte and one-cycle request
//   tx_busy           : UART Tx busy
//   busy              : sequencer not idle
//   last_status       : status byte of the most recent response
//   drop_cnt          : saturating count of bytes dropped during EXEC/response
// -----------------------------------------------------------------------------
module mpu_cmd_sequencer
   import mpu_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter int unsigned ALU_LAT     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_complete,
   input  logic       rx_error,
   input  logic [7:0] alu_result,
   output logic [7:0] a_reg,
   output logic [7:0] b_reg,
   output logic [3:0] f_reg,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic       busy,
   output logic [7:0] last_status,
   output logic [7:0] drop_cnt
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
   localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(ALU_LAT - 1);

   // The top only uses IDLE, GET_*, EXEC and SEND_ST; SEND_ST here means
   // "response in flight" and the serializer sequences the bytes.
   mpu_state_e       state_q, state_d;
   logic [7:0]       sa_q, sa_d, sb_q, sb_d, sop_q, sop_d;
   logic [7:0]       a_q, a_d, b_q, b_d;
   logic [3:0]       f_q, f_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [7:0]       drop_q, drop_d;

   logic       resp_start;
   logic [7:0] resp_st;
   logic [7:0] resp_res;
   logic       resp_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sa_q    <= 8'h00;
         sb_q    <= 8'h00;
         sop_q   <= 8'h00;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         f_q     <= 4'h0;
         tmo_q   <= '0;
         lat_q   <= '0;
         drop_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sop_q   <= sop_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         tmo_q   <= tmo_d;
         lat_q   <= lat_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      sop_d      = sop_q;
      a_d        = a_q;
      b_d        = b_q;
      f_d        = f_q;
      tmo_d      = tmo_q;
      lat_d      = lat_q;
      drop_d     = drop_q;
      resp_start = 1'b0;
      resp_st    = ST_OK;
      resp_res   = 8'h00;

      case (state_q)
         IDLE: begin
            if (rx_complete && rx_data == SYNC_BYTE) begin
               tmo_d   = '0;
               state_d = GET_A;
            end
         end
         GET_A, GET_B, GET_OP, GET_CS: begin
            // Priority: Rx error, then an arriving byte, then timeout.
            if (rx_error) begin
               resp_start = 1'b1;
               resp_st    = ST_RXERR;
               state_d    = SEND_ST;
            end else if (rx_complete) begin
               tmo_d = '0;
               case (state_q)
                  GET_A: begin
                     sa_d    = rx_data;
                     state_d = GET_B;
                  end
                  GET_B: begin
                     sb_d    = rx_data;
                     state_d = GET_OP;
                  end
                  GET_OP: begin
                     sop_d   = rx_data;
                     state_d = GET_CS;
                  end
                  default: begin
                     if (rx_data != frame_csum(sa_q, sb_q, sop_q)) begin
                        resp_start = 1'b1;
                        resp_st    = ST_CSUM;
                        state_d    = SEND_ST;
                     end else if (sop_q[7:4] != 4'h0) begin
                        resp_start = 1'b1;
                        resp_st    = ST_BADOP;
                        state_d    = SEND_ST;
                     end else begin
                        a_d     = sa_q;
                        b_d     = sb_q;
                        f_d     = sop_q[3:0];
                        lat_d   = '0;
                        state_d = EXEC;
                     end
                  end
               endcase
            end else if (tmo_q == TMO_MAX) begin
               resp_start = 1'b1;
               resp_st    = ST_TMO;
               state_d    = SEND_ST;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         EXEC: begin
            // Operands were loaded on the entry edge; alu_result is valid
            // at the ALU_LAT-th edge after that.
            if (lat_q == LAT_MAX) begin
               resp_start = 1'b1;
               resp_res   = alu_result;
               state_d    = SEND_ST;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         SEND_ST: begin
            if (resp_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rx_complete && (state_q == EXEC || state_q == SEND_ST) &&
          drop_q != 8'hFF) begin
         drop_d = drop_q + 8'd1;
      end
   end

   mpu_resp_tx u_resp_tx (
      .clk           (clk),
      .rst           (rst),
      .start_i       (resp_start),
      .st_byte_i     (resp_st),
      .res_byte_i    (resp_res),
      .tx_busy_i     (tx_busy),
      .tx_data_o     (tx_data),
      .tx_start_o    (tx_start),
      .last_status_o (last_status),
      .done_o        (resp_done)
   );

   assign a_reg    = a_q;
   assign b_reg    = b_q;
   assign f_reg    = f_q;
   assign busy     = (state_q != IDLE);
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mpu_cmd_sequencer
// Self-checking bench for mpu_cmd_sequencer with TIMEOUT_CYC=50, ALU_LAT=1.
// Contains a combinational ALU model, a UART Tx stub with programmable busy
// length, a table of frames with expected responses, hand-written corner
// sequences and a randomized section checked against a frame-level model.
// -----------------------------------------------------------------------------
module tb_mpu_cmd_sequencer;

   localparam int TMO = 50;

   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_complete;
   logic       rx_error;
   logic [7:0] alu_result;
   logic [7:0] a_reg, b_reg;
   logic [3:0] f_reg;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       busy;
   logic [7:0] last_status;
   logic [7:0] drop_cnt;

   mpu_cmd_sequencer #(
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TMO),
      .ALU_LAT     (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_complete (rx_complete),
      .rx_error    (rx_error),
      .alu_result  (alu_result),
      .a_reg       (a_reg),
      .b_reg       (b_reg),
      .f_reg       (f_reg),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .busy        (busy),
      .last_status (last_status),
      .drop_cnt    (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: 1 add, 2 xor, 3 and, anything else subtract.
   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] f);
      case (f)
         4'd1:    return a + b;
         4'd2:    return a ^ b;
         4'd3:    return a & b;
         default: return a - b;
      endcase
   endfunction

   assign alu_result = alu_fn(a_reg, b_reg, f_reg);

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // UART Tx stub: records every transmitted byte; busy rises the cycle after
   // tx_start and stays high for busy_len cycles.
   logic [7:0] txq[$];
   int n_starts        = 0;
   int first_start_cyc = 0;
   int busy_len        = 3;
   int busy_cnt        = 0;
   bit pend            = 1'b0;

   initial begin
      tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
         end
         if (pend) begin
            tx_busy  = 1'b1;
            busy_cnt = busy_len;
            pend     = 1'b0;
         end
         if (tx_start) begin
            if (txq.size() == 0) first_start_cyc = cyc;
            txq.push_back(tx_data);
            n_starts++;
            pend = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int last_byte_cyc = 0;

   // Waits gap idle cycles, then presents one byte for one cycle.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit err = 1'b0);
      repeat (gap) tick();
      rx_data     = b;
      rx_complete = 1'b1;
      rx_error    = err;
      tick();
      last_byte_cyc = cyc;
      rx_complete = 1'b0;
      rx_error    = 1'b0;
      rx_data     = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] cs, input int gap);
      send_byte(8'hA5, gap);
      send_byte(a, gap);
      send_byte(b, gap);
      send_byte(op, gap);
      send_byte(cs, gap);
   endtask

   task automatic wait_resp(input string tag);
      int n;
      n = 0;
      while (!(txq.size() >= 2 && busy == 1'b0) && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_resp_wait"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic check_resp(input string tag, input logic [7:0] st, input logic [7:0] res);
      logic [7:0] g0, g1;
      g0 = (txq.size() > 0) ? txq[0] : 8'hxx;
      g1 = (txq.size() > 1) ? txq[1] : 8'hxx;
      check({tag, "_nbytes"}, txq.size(), 2);
      check({tag, "_st"}, g0, st);
      check({tag, "_res"}, g1, res);
      check({tag, "_last_status"}, last_status, st);
   endtask

   task automatic check_abf(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] f);
      check({tag, "_a_reg"}, a_reg, a);
      check({tag, "_b_reg"}, b_reg, b);
      check({tag, "_f_reg"}, f_reg, f);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a_reg"}, a_reg, 0);
      check({tag, "_b_reg"}, b_reg, 0);
      check({tag, "_f_reg"}, f_reg, 0);
      check({tag, "_tx_data"}, tx_data, 0);
      check({tag, "_tx_start"}, tx_start, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_last_status"}, last_status, 0);
      check({tag, "_drop_cnt"}, drop_cnt, 0);
   endtask

   typedef struct {
      logic [7:0] a, b, op, cs;
      logic [7:0] exp_st, exp_res, exp_a, exp_b;
      logic [3:0] exp_f;
   } vec_t;

   vec_t vecs[8];

   // Frame-level reference state.
   logic [7:0] m_a, m_b;
   logic [3:0] m_f;
   int         m_drop;

   initial begin
      logic [7:0] ra, rb, rop, rcs, rst_exp, rres_exp, junk;
      int         gap, starts_before, n;

      vecs[0] = '{8'h12, 8'h34, 8'h01, 8'h27, 8'h00, 8'h46, 8'h12, 8'h34, 4'h1};
      vecs[1] = '{8'h12, 8'h34, 8'h01, 8'h28, 8'hE1, 8'h00, 8'h12, 8'h34, 4'h1};
      vecs[2] = '{8'h01, 8'h02, 8'h13, 8'h10, 8'hE4, 8'h00, 8'h12, 8'h34, 4'h1};
      vecs[3] = '{8'hF0, 8'h0F, 8'h02, 8'hFD, 8'h00, 8'hFF, 8'hF0, 8'h0F, 4'h2};
      vecs[4] = '{8'h55, 8'hAA, 8'hF1, 8'h0E, 8'hE4, 8'h00, 8'hF0, 8'h0F, 4'h2};
      vecs[5] = '{8'h55, 8'hAA, 8'hF1, 8'h0F, 8'hE1, 8'h00, 8'hF0, 8'h0F, 4'h2};
      vecs[6] = '{8'h80, 8'h80, 8'h01, 8'h01, 8'h00, 8'h00, 8'h80, 8'h80, 4'h1};
      vecs[7] = '{8'h6F, 8'hF6, 8'h03, 8'h9A, 8'h00, 8'h66, 8'h6F, 8'hF6, 4'h3};

      rst         = 1'b1;
      rx_data     = 8'h00;
      rx_complete = 1'b0;
      rx_error    = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      m_drop = 0;

      // Table-driven frames.
      for (int i = 0; i < 8; i++) begin
         txq.delete();
         send_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cs, i % 3);
         if (i == 0) begin
            n = 0;
            while (txq.size() == 0 && n < 20) begin
               tick();
               n++;
            end
            check("ok_latency", first_start_cyc - last_byte_cyc, 2);
         end
         wait_resp($sformatf("vec%0d", i));
         check_resp($sformatf("vec%0d", i), vecs[i].exp_st, vecs[i].exp_res);
         check_abf($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_f);
         check($sformatf("vec%0d_busy", i), busy, 0);
      end

      // Bytes spaced exactly TIMEOUT_CYC cycles apart are still accepted.
      txq.delete();
      send_byte(8'hA5, 2);
      send_byte(8'h12, TMO - 1);
      send_byte(8'h34, TMO - 1);
      send_byte(8'h01, TMO - 1);
      send_byte(8'h27, TMO - 1);
      wait_resp("tmo_edge");
      check_resp("tmo_edge", 8'h00, 8'h46);
      check_abf("tmo_edge", 8'h12, 8'h34, 4'h1);

      // Silence after A5,12 times out.
      txq.delete();
      send_byte(8'hA5, 1);
      send_byte(8'h12, 0);
      n = 0;
      while (txq.size() == 0 && n < 200) begin
         tick();
         n++;
      end
      check("tmo_latency", first_start_cyc - last_byte_cyc, TMO + 1);
      wait_resp("tmo");
      check_resp("tmo", 8'hE3, 8'h00);
      check_abf("tmo", 8'h12, 8'h34, 4'h1);
      check("tmo_busy", busy, 0);

      txq.delete();
      send_frame(8'h6F, 8'hF6, 8'h03, 8'h9A, 0);
      wait_resp("after_tmo");
      check_resp("after_tmo", 8'h00, 8'h66);
      check_abf("after_tmo", 8'h6F, 8'hF6, 4'h3);

      // Rx error together with a byte in GET_B: error wins, byte discarded.
      txq.delete();
      send_byte(8'hA5, 1);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0, 1'b1);
      wait_resp("rxerr");
      check_resp("rxerr", 8'hE2, 8'h00);
      check_abf("rxerr", 8'h6F, 8'hF6, 4'h3);
      check("rxerr_drop", drop_cnt, m_drop);
      check("rxerr_busy", busy, 0);

      // Bytes during WAIT_ST are dropped; the dropped A5 starts nothing.
      busy_len = 200;
      txq.delete();
      send_frame(8'h12, 8'h34, 8'h01, 8'h27, 0);
      n = 0;
      while (txq.size() == 0 && n < 50) begin
         tick();
         n++;
      end
      send_byte(8'h07, 3);
      send_byte(8'hA5, 2);
      m_drop += 2;
      check("drop_cnt_wait_st", drop_cnt, m_drop);
      wait_resp("drop");
      check_resp("drop", 8'h00, 8'h46);
      repeat (5) tick();
      check("drop_no_new_frame", busy, 0);
      check("drop_no_extra_tx", txq.size(), 2);
      check("drop_cnt_after", drop_cnt, m_drop);

      // Randomized frames against the frame-level model.
      m_a = 8'h12;
      m_b = 8'h34;
      m_f = 4'h1;
      for (int k = 0; k < 30; k++) begin
         busy_len = int'($urandom_range(1, 6));
         if ($urandom_range(0, 3) == 0) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk, int'($urandom_range(0, 4)));
         end
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rop = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) rop[7:4] = 4'($urandom_range(1, 15));
         rcs = ra ^ rb ^ rop;
         if ($urandom_range(0, 4) == 0) rcs = rcs ^ 8'($urandom_range(1, 255));
         if (rcs != (ra ^ rb ^ rop)) begin
            rst_exp  = 8'hE1;
            rres_exp = 8'h00;
         end else if (rop > 8'h0F) begin
            rst_exp  = 8'hE4;
            rres_exp = 8'h00;
         end else begin
            m_a      = ra;
            m_b      = rb;
            m_f      = rop[3:0];
            rst_exp  = 8'h00;
            rres_exp = alu_fn(ra, rb, rop[3:0]);
         end
         gap = int'($urandom_range(0, 8));
         txq.delete();
         send_frame(ra, rb, rop, rcs, gap);
         if ($urandom_range(0, 1) == 1) begin
            send_byte(8'($urandom_range(0, 255)), 0);
            m_drop++;
         end
         wait_resp($sformatf("rnd%0d", k));
         check_resp($sformatf("rnd%0d", k), rst_exp, rres_exp);
         check_abf($sformatf("rnd%0d", k), m_a, m_b, m_f);
         check($sformatf("rnd%0d_drop", k), drop_cnt, m_drop);
      end

      // Reset in the middle of WAIT_RES abandons the response.
      busy_len = 200;
      txq.delete();
      send_frame(8'h12, 8'h34, 8'h01, 8'h27, 0);
      n = 0;
      while (txq.size() < 2 && n < 1000) begin
         tick();
         n++;
      end
      check("rst_mid_second_byte_seen", txq.size(), 2);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check_all_zero("rst_mid");
      rst = 1'b0;
      starts_before = n_starts;
      repeat (300) tick();
      check("rst_mid_no_tx_start", n_starts - starts_before, 0);
      check("rst_mid_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
